// File: rtl/mips_fetch_decode.sv
// Fetch-and-decode front end: writable program memory, PC sequencing,
// field split and kind classification, one decoded word per cycle over valid/ready.
module mips_fetch_decode #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [PW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic [PW:0]   prog_len,
    input  logic          start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   instr,
    output logic [PW-1:0] pc,
    output logic [5:0]    opcode,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [4:0]    shamt,
    output logic [5:0]    funct,
    output logic [31:0]   imm_se,
    output logic [1:0]    kind,
    output logic [7:0]    illegal_cnt,
    output logic          done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef enum logic [1:0] {K_RALU = 2'b00, K_LW = 2'b01, K_SW = 2'b10, K_ILL = 2'b11} kind_t;

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [PW:0] fp_q;
    logic [PW:0] len_q;
    logic [31:0] instr_q;
    logic [PW-1:0] pc_q;
    kind_t       kind_q;
    logic        valid_q;
    logic [7:0]  ill_q;

    logic [31:0] word;
    kind_t       kind_d;
    logic        start_go;
    logic        load;
    logic        accept;

    assign word   = mem[fp_q[PW-1:0]];
    assign accept = valid_q && out_ready;

    always_comb begin
        kind_d = K_ILL;
        case (word[31:26])
            6'h00: begin
                case (word[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: kind_d = K_RALU;
                    default:                           kind_d = K_ILL;
                endcase
            end
            6'h23:   kind_d = K_LW;
            6'h2B:   kind_d = K_SW;
            default: kind_d = K_ILL;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_go = 1'b1;
                    state_d  = (prog_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                load = (!valid_q || out_ready) && (fp_q < len_q);
                if ((fp_q == len_q) && (!valid_q || out_ready))
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Memory has no reset so its contents survive rst_n; RUN blocks writes.
    always_ff @(posedge clk) begin
        if (prog_we && state_q != ST_RUN)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_q    <= '0;
            len_q   <= '0;
            instr_q <= '0;
            pc_q    <= '0;
            kind_q  <= K_RALU;
            valid_q <= 1'b0;
            ill_q   <= '0;
        end else if (start_go) begin
            len_q   <= prog_len;
            fp_q    <= '0;
            ill_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load) begin
                instr_q <= word;
                pc_q    <= fp_q[PW-1:0];
                kind_q  <= kind_d;
                valid_q <= 1'b1;
                fp_q    <= fp_q + (PW+1)'(1);
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            if (accept && kind_q == K_ILL && ill_q != '1)
                ill_q <= ill_q + 8'd1;
        end
    end

    assign out_valid   = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign opcode      = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign shamt       = instr_q[10:6];
    assign funct       = instr_q[5:0];
    assign imm_se      = {{16{instr_q[15]}}, instr_q[15:0]};
    assign kind        = kind_q;
    assign illegal_cnt = ill_q;
    assign done        = (state_q == ST_DONE);

endmodule

// File: doc/mips_fetch_decode.md
# mips_fetch_decode

Instruction fetch-and-decode front end for the lab MIPS core. It holds a small writable program memory, sequences a program counter through it, and splits each instruction word into its fields. It also classifies the instruction as R-type ALU, lw, sw or illegal, and presents one decoded instruction per cycle to the downstream execute/register-file stage over a valid/ready handshake. The block ends in a DONE state once the programmed instruction count has been delivered.

## Interface
- DEPTH, 16, program memory depth in 32-bit words; must be a power of two ≥ 2; PW = $clog2(DEPTH)
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- prog_we  in  1  program write strobe; honoured only in IDLE or DONE
- prog_addr  in  PW  program write word address
- prog_data  in  32  program write data
- prog_len  in  PW+1  number of instructions to run; sampled on the start edge
- start  in  1  begin execution at pc 0; honoured only in IDLE or DONE
- out_valid  out  1  decoded instruction present on the outputs
- out_ready  in  1  downstream accepts the instruction this cycle
- instr  out  32  raw instruction word
- pc  out  PW  word index of instr
- opcode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- imm_se  out  32  instr[15:0], sign-extended
- kind  out  2  00 R-ALU, 01 lw, 10 sw, 11 illegal
- illegal_cnt  out  8  illegal instructions accepted since start; saturates at 255
- done  out  1  high while in DONE

## Operation
- States: IDLE (after reset), RUN, DONE.
- IDLE/DONE + start:
  - latch prog_len into len_q, clear fetch pointer fp and illegal_cnt, drop out_valid.
  - If prog_len == 0, go to DONE (or stay in it); otherwise go to RUN.
- RUN load condition: (!out_valid || out_ready) && fp < len_q.
  - On load: the output register takes mem[fp] (combinational read), pc = fp, all decoded fields; out_valid = 1; fp increments.
- RUN with out_valid && out_ready and no load possible: out_valid = 0.
- RUN → DONE when fp == len_q and either out_valid == 0 or the current word is accepted.
- Holding: while out_valid && !out_ready, every output stays stable.
- kind decode:
  - R-ALU: opcode 0x00 and funct ∈ {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt}.
  - lw: opcode 0x23. sw: opcode 0x2B.
  - illegal: everything else, including opcode 0 with any other funct.
- Illegal words are still forwarded. illegal_cnt increments on acceptance of a kind == 11 word, saturating at 255.
- Program writes:
  - Written on the edge where prog_we is high in IDLE or DONE; ignored in RUN.
  - A write during DONE does not affect out_* contents.
- start in RUN is ignored.
- Program memory is not reset. Its contents survive rst_n.

## Timing
- Reset values: state IDLE, fp 0, len_q 0, out_valid 0, instr/pc/all fields/imm_se 0, kind 00, illegal_cnt 0, done 0.
- Reset assertion mid-RUN: outputs take reset values immediately (asynchronous). Execution resumes only on a new start.
- First-word latency:
  - start sampled at edge k → RUN after k.
  - First word loaded at edge k+1; out_valid is high after k+1.
- Throughput is 1 instruction/cycle with out_ready held high. Last word of N is visible after edge k+N.
- DONE entry: done rises after the edge that accepts the last word. Under constant ready that is edge k+N+1.
- Back-pressure: no bubble is inserted. Accept and load occur on the same edge.
- A write to address fp in IDLE on the same edge as start is written first. The word is visible to the first fetch at k+1.

## Test plan
- Load 0x01084820 at addr 0, prog_len 1, start, ready = 1 → after k+1: opcode 0, rs 8, rt 8, rd 9, shamt 0, funct 0x20, kind 00, pc 0. After k+2: out_valid 0, done 1.
- Load 0x8E0B0004 (lw) and 0xACBD0004 (sw), prog_len 2, ready = 1:
  - word 1: kind 01, rs 16, rt 11, imm_se 0x00000004;
  - word 2: kind 10, rs 5, rt 29;
  - consecutive cycles, done after k+3.
- Load 0x08000000, 0x0000000C, 0x2108FFFF, prog_len 3 → all three get kind 11; last one has imm_se 0xFFFFFFFF; illegal_cnt reaches 3.
- 15-word program with out_ready toggling 1,0,0,1 → every word appears exactly once in pc order 0..14, outputs stable while stalled, done only after pc 14 is accepted.
- rst_n low for 1 cycle during RUN at pc 5 → out_valid 0 and pc 0 at once. Then start again → pc 0 reappears with unchanged memory contents.
- prog_len 0 start → done after k, out_valid never rises. prog_we during RUN → memory unchanged on the next run.
